// File: rtl/pc_unit.sv
// Program-counter unit: next-PC selection, stall/halt control and fetch handshake.
// Optional misaligned-redirect trap and mret support when PC_TRAP_EN is defined.
module pc_unit #(
  parameter int unsigned      XLEN         = 32,
  parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
  parameter int unsigned      INC          = 4,
  parameter int unsigned      ALIGN        = 2,
  parameter logic [XLEN-1:0]  TRAP_VECTOR  = XLEN'(32'h100)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            stall,
  input  logic            fetch_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            halt,
  input  logic            resume,
  input  logic            mret,
  output logic [XLEN-1:0] pc_out,
  output logic            pc_valid,
  output logic [XLEN-1:0] epc,
  output logic            trap_taken,
  output logic [1:0]      state
);

`ifdef PC_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  localparam logic [XLEN-1:0] IncVal  = XLEN'(INC);
  localparam logic [XLEN-1:0] LowMask = XLEN'((64'd1 << ALIGN) - 64'd1);

  typedef enum logic [1:0] {
    StBoot   = 2'd0,
    StRun    = 2'd1,
    StHalted = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            pc_valid_q;
  logic [XLEN-1:0] epc_q, epc_d;
  logic            trap_q, trap_d;

  logic            accept;
  logic            misaligned;
  logic            take_trap;
  logic            mret_act;
  logic [XLEN-1:0] redir_pc;

  assign accept     = pc_valid_q & fetch_ready & ~stall;
  assign misaligned = |(redirect_target & LowMask);
  assign take_trap  = TrapEn & redirect_valid & misaligned;
  assign mret_act   = TrapEn & mret;

  // Without the trap build, misaligned targets are silently truncated.
  always_comb begin
    redir_pc = redirect_target & ~LowMask;
    if (take_trap) begin
      redir_pc = TRAP_VECTOR;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    trap_d  = 1'b0;

    unique case (state_q)
      StBoot: begin
        state_d = StRun;
        pc_d    = RESET_VECTOR;
      end

      StRun: begin
        if (halt) begin
          state_d = StHalted;
        end
        if (mret_act) begin
          pc_d = epc_q;
        end else if (redirect_valid) begin
          pc_d = redir_pc;
          if (take_trap) begin
            epc_d  = redirect_target;
            trap_d = 1'b1;
          end
        end else if (halt) begin
          pc_d = pc_q;
        end else if (accept) begin
          pc_d = pc_q + IncVal;
        end
      end

      StHalted: begin
        if (resume && !halt) begin
          state_d = StRun;
        end
        // Debugger set-PC: redirect still lands while halted.
        if (redirect_valid) begin
          pc_d = redir_pc;
          if (take_trap) begin
            epc_d  = redirect_target;
            trap_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = StBoot;
        pc_d    = RESET_VECTOR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= StBoot;
      pc_q       <= RESET_VECTOR;
      pc_valid_q <= 1'b0;
      epc_q      <= '0;
      trap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_valid_q <= (state_d == StRun);
      epc_q      <= epc_d;
      trap_q     <= trap_d;
    end
  end

  assign pc_out     = pc_q;
  assign pc_valid   = pc_valid_q;
  assign epc        = epc_q;
  assign trap_taken = trap_q;
  assign state      = state_q;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: table-driven vectors through a scoreboard queue,
// plus an XLEN=8 instance for the wrap-around and alignment corner cases.
module tb_pc_unit;

`ifdef PC_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  localparam logic [31:0] PcMis  = TrapEn ? 32'h100 : 32'h40;
  localparam logic [31:0] EpcMis = TrapEn ? 32'h42 : 32'h0;
  localparam logic [31:0] PcRet  = TrapEn ? 32'h42 : 32'h40;

  logic        clk = 1'b0;
  logic        reset_n, stall, fetch_ready, redirect_valid, halt, resume, mret;
  logic [31:0] redirect_target;
  logic [31:0] pc_out, epc;
  logic        pc_valid, trap_taken;
  logic [1:0]  state;

  logic        w_reset_n, w_stall, w_fetch_ready, w_redirect_valid, w_halt, w_resume, w_mret;
  logic [7:0]  w_redirect_target, w_pc_out, w_epc;
  logic        w_pc_valid, w_trap_taken;
  logic [1:0]  w_state;

  always #5 clk = ~clk;

  pc_unit dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .stall          (stall),
    .fetch_ready    (fetch_ready),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .halt           (halt),
    .resume         (resume),
    .mret           (mret),
    .pc_out         (pc_out),
    .pc_valid       (pc_valid),
    .epc            (epc),
    .trap_taken     (trap_taken),
    .state          (state)
  );

  pc_unit #(
    .XLEN        (8),
    .RESET_VECTOR(8'h00),
    .INC         (4),
    .ALIGN       (2),
    .TRAP_VECTOR (8'h80)
  ) dut8 (
    .clk            (clk),
    .reset_n        (w_reset_n),
    .stall          (w_stall),
    .fetch_ready    (w_fetch_ready),
    .redirect_valid (w_redirect_valid),
    .redirect_target(w_redirect_target),
    .halt           (w_halt),
    .resume         (w_resume),
    .mret           (w_mret),
    .pc_out         (w_pc_out),
    .pc_valid       (w_pc_valid),
    .epc            (w_epc),
    .trap_taken     (w_trap_taken),
    .state          (w_state)
  );

  typedef struct {
    logic        rst_n, stall, rdy, rv;
    logic [31:0] tgt;
    logic        halt, resume, mret;
    logic [31:0] pc;
    logic        valid;
    logic [1:0]  st;
    logic [31:0] epc;
    logic        trap;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] pc;
    logic        valid;
    logic [1:0]  st;
    logic [31:0] epc;
    logic        trap;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(logic rst_n, logic stl, logic rdy, logic rv, logic [31:0] tgt,
                              logic hlt, logic res, logic mr, logic [31:0] pc, logic valid,
                              logic [1:0] st, logic [31:0] ep, logic trap);
    vec_t v;
    v.rst_n = rst_n; v.stall = stl; v.rdy = rdy; v.rv = rv; v.tgt = tgt;
    v.halt = hlt; v.resume = res; v.mret = mr;
    v.pc = pc; v.valid = valid; v.st = st; v.epc = ep; v.trap = trap;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset_n         = v.rst_n;
    stall           = v.stall;
    fetch_ready     = v.rdy;
    redirect_valid  = v.rv;
    redirect_target = v.tgt;
    halt            = v.halt;
    resume          = v.resume;
    mret            = v.mret;
  endtask

  initial begin
    exp_t e;
    reset_n = 1'b0; stall = 1'b0; fetch_ready = 1'b1; redirect_valid = 1'b0;
    redirect_target = '0; halt = 1'b0; resume = 1'b0; mret = 1'b0;
    w_reset_n = 1'b0; w_stall = 1'b0; w_fetch_ready = 1'b0; w_redirect_valid = 1'b0;
    w_redirect_target = '0; w_halt = 1'b0; w_resume = 1'b0; w_mret = 1'b0;

    //            rst stl rdy rv  tgt      hlt res mret | pc     vld st epc     trap
    vecs.push_back(mk(1, 0, 1, 0, 32'h0,   0, 0, 0, 32'h0,   1, 1, 32'h0,  0));
    vecs.push_back(mk(1, 0, 1, 0, 32'h0,   0, 0, 0, 32'h4,   1, 1, 32'h0,  0));
    vecs.push_back(mk(1, 0, 1, 0, 32'h0,   0, 0, 0, 32'h8,   1, 1, 32'h0,  0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,   0, 0, 0, 32'h8,   1, 1, 32'h0,  0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,   0, 0, 0, 32'h8,   1, 1, 32'h0,  0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,   0, 0, 0, 32'h8,   1, 1, 32'h0,  0));
    vecs.push_back(mk(1, 0, 1, 0, 32'h0,   0, 0, 0, 32'hC,   1, 1, 32'h0,  0));
    vecs.push_back(mk(1, 1, 1, 0, 32'h0,   0, 0, 0, 32'hC,   1, 1, 32'h0,  0));
    vecs.push_back(mk(1, 1, 1, 0, 32'h0,   0, 0, 0, 32'hC,   1, 1, 32'h0,  0));
    vecs.push_back(mk(1, 0, 1, 0, 32'h0,   0, 0, 0, 32'h10,  1, 1, 32'h0,  0));
    vecs.push_back(mk(1, 0, 1, 0, 32'h0,   1, 0, 0, 32'h10,  0, 2, 32'h0,  0));
    vecs.push_back(mk(1, 0, 1, 1, 32'h80,  0, 0, 0, 32'h80,  0, 2, 32'h0,  0));
    vecs.push_back(mk(1, 0, 1, 0, 32'h0,   0, 1, 0, 32'h80,  1, 1, 32'h0,  0));
    vecs.push_back(mk(1, 0, 1, 0, 32'h0,   0, 0, 0, 32'h84,  1, 1, 32'h0,  0));
    vecs.push_back(mk(1, 1, 0, 1, 32'h40,  0, 0, 0, 32'h40,  1, 1, 32'h0,  0));
    vecs.push_back(mk(1, 0, 1, 0, 32'h0,   0, 0, 0, 32'h44,  1, 1, 32'h0,  0));
    vecs.push_back(mk(1, 0, 1, 1, 32'h42,  0, 0, 0, PcMis,   1, 1, EpcMis, TrapEn));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,   0, 0, 1, PcRet,   1, 1, EpcMis, 0));
    vecs.push_back(mk(1, 0, 1, 0, 32'h0,   1, 1, 0, PcRet,   0, 2, EpcMis, 0));
    vecs.push_back(mk(1, 0, 1, 0, 32'h0,   0, 1, 0, PcRet,   1, 1, EpcMis, 0));
    vecs.push_back(mk(1, 0, 1, 1, 32'h300, 1, 0, 0, 32'h300, 0, 2, EpcMis, 0));
    vecs.push_back(mk(1, 0, 1, 0, 32'h0,   0, 1, 0, 32'h300, 1, 1, EpcMis, 0));
    vecs.push_back(mk(0, 1, 1, 1, 32'h200, 1, 0, 0, 32'h0,   0, 0, 32'h0,  0));
    vecs.push_back(mk(1, 0, 1, 0, 32'h0,   0, 0, 0, 32'h0,   1, 1, 32'h0,  0));
    vecs.push_back(mk(1, 0, 1, 0, 32'h0,   0, 0, 0, 32'h4,   1, 1, 32'h0,  0));

    repeat (2) @(posedge clk);
    #1;
    check("reset.pc", pc_out, 32'h0);
    check("reset.valid", {31'b0, pc_valid}, 32'h0);
    check("reset.state", {30'b0, state}, 32'h0);
    check("reset.epc", epc, 32'h0);
    check("reset.trap", {31'b0, trap_taken}, 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      e.idx = i; e.pc = vecs[i].pc; e.valid = vecs[i].valid; e.st = vecs[i].st;
      e.epc = vecs[i].epc; e.trap = vecs[i].trap;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard: got empty queue, expected entry for v%0d", i);
      end else begin
        e = sb.pop_front();
        check($sformatf("v%0d.pc", e.idx), pc_out, e.pc);
        check($sformatf("v%0d.valid", e.idx), {31'b0, pc_valid}, {31'b0, e.valid});
        check($sformatf("v%0d.state", e.idx), {30'b0, state}, {30'b0, e.st});
        check($sformatf("v%0d.epc", e.idx), epc, e.epc);
        check($sformatf("v%0d.trap", e.idx), {31'b0, trap_taken}, {31'b0, e.trap});
      end
    end

    // XLEN=8 instance: increment wrap and truncated/trapped misaligned redirect.
    w_reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("w8.boot_pc", {24'b0, w_pc_out}, 32'h0);
    check("w8.boot_state", {30'b0, w_state}, 32'h1);
    w_redirect_valid = 1'b1; w_redirect_target = 8'hFC;
    @(posedge clk);
    #1;
    check("w8.redirect_fc", {24'b0, w_pc_out}, 32'hFC);
    w_redirect_valid = 1'b0; w_fetch_ready = 1'b1;
    @(posedge clk);
    #1;
    check("w8.wrap", {24'b0, w_pc_out}, 32'h0);
    check("w8.wrap_valid", {31'b0, w_pc_valid}, 32'h1);
    w_fetch_ready = 1'b0; w_redirect_valid = 1'b1; w_redirect_target = 8'hFF;
    @(posedge clk);
    #1;
    check("w8.misaligned_pc", {24'b0, w_pc_out}, TrapEn ? 32'h80 : 32'hFC);
    check("w8.misaligned_trap", {31'b0, w_trap_taken}, {31'b0, TrapEn});
    w_redirect_valid = 1'b0;
    @(posedge clk);
    #1;
    check("w8.trap_pulse_end", {31'b0, w_trap_taken}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the single-cycle/multicycle core. It replaces the bare PC register and owns next-PC selection: sequential increment, branch/jump redirect, stall, halt/resume, and a valid/ready fetch handshake toward instruction memory. It sits between the control/branch logic and the instruction-fetch port. Optionally it traps on misaligned redirect targets and supports return from trap.

## Interface
Parameters:
- `XLEN`, 32: PC width in bits.
- `RESET_VECTOR`, 0: PC value after reset.
- `INC`, 4: sequential increment in bytes.
- `ALIGN`, 2: number of low PC bits that must be zero.
- `TRAP_VECTOR`, 32'h100: PC loaded on a misalignment trap. Used only with `PC_TRAP_EN`.

Ports:
- `clk` in 1: clock, rising edge.
- `reset_n` in 1: synchronous reset, active-low.
- `stall` in 1: freeze the PC; pipeline hazard.
- `fetch_ready` in 1: instruction memory accepts `pc_out` this cycle.
- `redirect_valid` in 1: branch taken or jump.
- `redirect_target` in XLEN: target address.
- `halt` in 1: enter HALTED.
- `resume` in 1: leave HALTED.
- `mret` in 1: return from trap. Used only with `PC_TRAP_EN`; ignored otherwise.
- `pc_out` out XLEN: current PC.
- `pc_valid` out 1: `pc_out` is a fetch request.
- `epc` out XLEN: saved exception PC. Constant 0 without `PC_TRAP_EN`.
- `trap_taken` out 1: one-cycle pulse when a trap is taken.
- `state` out 2: 0 BOOT, 1 RUN, 2 HALTED.

## Operation
- States: BOOT → RUN (unconditionally, after 1 cycle). RUN → HALTED on `halt`. HALTED → RUN on `resume`. `halt` wins over `resume` when both are high.
- BOOT:
  - `pc_out` = RESET_VECTOR.
  - `pc_valid` = 0.
- RUN:
  - `pc_valid` = 1.
  - Fetch accepted = `pc_valid & fetch_ready & ~stall`.
- Next-PC priority in RUN, highest first:
  1. `mret`, trap build only: load `epc`.
  2. `redirect_valid`: load target. This ignores `stall` and `fetch_ready`.
  3. `halt`: hold the PC.
  4. `stall` or no accept: hold the PC.
  5. Otherwise: PC + INC.
- Arithmetic is modulo 2^XLEN. The increment wraps from 2^XLEN−INC to 0, with no flag.
- Redirect alignment without `PC_TRAP_EN`: the low ALIGN bits of the target are forced to 0.
- HALTED:
  - `pc_valid` = 0 and the PC is held.
  - `redirect_valid` still loads the PC (debugger set-PC) and the unit stays HALTED.
  - On `resume`, fetch restarts at the held or loaded PC.
- `trap_taken` = 0 except for the one-cycle trap pulse.

## Timing
- All outputs are registered. Every change appears the cycle after the causing edge.
- Redirect latency: 1 cycle. The target is on `pc_out` the cycle after `redirect_valid` is sampled high.
- An accepted fetch advances `pc_out` on the next cycle. A request that is not accepted keeps `pc_out` stable. `pc_valid` is never dropped in RUN without `halt`.
- Reset values (`reset_n` = 0 sampled at an edge):
  - `pc_out` = RESET_VECTOR.
  - `pc_valid` = 0.
  - `epc` = 0.
  - `trap_taken` = 0.
  - `state` = BOOT.
- Reset overrides every other input, including mid-stall, mid-halt and simultaneous redirect.
- First fetch request: 1 cycle after reset is released (BOOT cycle).

## Configuration
- Macro: `PC_TRAP_EN`.
- Defined:
  - A redirect (not `mret`) whose target has any of the low ALIGN bits set loads `pc_out` = TRAP_VECTOR and `epc` = that target.
  - `trap_taken` pulses for 1 cycle.
  - `mret` loads `pc_out` = `epc`.
  - Trap vs halt in the same cycle: the trap is taken, then the unit halts.
- Undefined:
  - No trap logic; `epc` = 0 and `trap_taken` = 0 constantly.
  - `mret` is ignored.
  - Misaligned targets are truncated as described in Operation.

## Test plan
- Reset then run: `reset_n` low for 2 cycles, release, `fetch_ready` = 1 → `pc_out` = 0 with `pc_valid` = 0 for 1 cycle, then 0, 4, 8, 12 on successive cycles.
- Backpressure:
  - `fetch_ready` = 0 for 3 cycles at PC 8 → `pc_out` holds 8 and `pc_valid` stays 1.
  - `stall` = 1 for 2 cycles → PC holds.
- Redirect under stall: `stall` = 1 and `redirect_valid` = 1 with target 0x40 → `pc_out` = 0x40 next cycle. Wrap case: XLEN = 8 with PC 0xFC → next PC is 0x00.
- Halt/resume:
  - `halt` at PC 0x10 → `pc_valid` = 0 and `state` = 2.
  - Redirect to 0x80 while halted → PC = 0x80 and still halted.
  - `resume` → fetch restarts at 0x80.
- Misaligned redirect to 0x42:
  - With `PC_TRAP_EN`: `pc_out` = 0x100, `epc` = 0x42, one `trap_taken` pulse; then `mret` → `pc_out` = 0x42.
  - Without: `pc_out` = 0x40 and no trap.
- Mid-operation reset: `reset_n` low during a redirect with target 0x200 → `pc_out` = RESET_VECTOR and `state` = BOOT.
